// File: rtl/seg_frame_decoder.sv
// Recovers the 8-digit frame shown on a multiplexed active-low 7-segment display
// by watching the scan lines (AN) and segment lines (led) until each digit settles.
module seg_frame_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  AN,
  input  logic [6:0]  led,
  output logic [39:0] frame,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        bad_an,
  output logic        scan_stall
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] STALL_MAX   = TW'(STALL_CYCLES);
  localparam logic [4:0]    BLANK       = 5'd16;
  localparam bit            SETTLE_ONE  = (SETTLE_CYCLES <= 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [14:0]     prev_reg, prev_next;
  logic [7:0]      mask_reg, mask_next;
  logic [TW-1:0]   stall_cnt_reg, stall_cnt_next;
  logic            first_reg;
  logic [39:0]     frame_reg;
  logic            valid_reg;
  logic            changed_reg;
  logic            stall_reg;

  logic [39:0]     work_flat;
  logic [7:0]      an_sel;
  logic            an_onehot;
  logic [2:0]      pos;
  logic [4:0]      cap_code;
  logic [14:0]     sample;
  logic            capture;
  logic            mask_done;

  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] code;
    case (pat)
      7'b1000000: code = 5'd0;
      7'b1111001: code = 5'd1;
      7'b0100100: code = 5'd2;
      7'b0110000: code = 5'd3;
      7'b0011001: code = 5'd4;
      7'b0010010: code = 5'd5;
      7'b0000010: code = 5'd6;
      7'b1111000: code = 5'd7;
      7'b0000000: code = 5'd8;
      7'b0010000: code = 5'd9;
      7'b0001000: code = 5'd10;
      7'b0000011: code = 5'd11;
      7'b1000110: code = 5'd12;
      7'b0100001: code = 5'd13;
      7'b0000110: code = 5'd14;
      7'b0001110: code = 5'd15;
      7'b1111111: code = 5'd16;
      7'b0111111: code = 5'd17;
      default:    code = 5'd31;
    endcase
    return code;
  endfunction

  // AN is active-low: a valid selection has exactly one bit set in ~AN.
  always_comb begin
    an_sel    = ~AN;
    an_onehot = (an_sel != 8'h00) && ((an_sel & (an_sel - 8'd1)) == 8'h00);
    pos       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_sel[i]) pos = 3'(i);
    end
  end

  assign bad_an   = ~an_onehot;
  assign sample   = {AN, led};
  assign cap_code = decode_seg(led);

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    prev_next       = prev_reg;
    capture         = 1'b0;
    case (state_reg)
      ST_WAIT: begin
        if (an_onehot) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SW'(1);
          prev_next       = sample;
        end
      end
      ST_SETTLE: begin
        if (sample == prev_reg) begin
          if (settle_cnt_reg >= SETTLE_LAST) begin
            capture         = 1'b1;
            state_next      = ST_HOLD;
            settle_cnt_next = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + SW'(1);
          end
        end else if (an_onehot) begin
          settle_cnt_next = SW'(1);
          prev_next       = sample;
        end else begin
          state_next      = ST_WAIT;
          settle_cnt_next = '0;
        end
      end
      ST_HOLD: begin
        // Only a change of scan line releases HOLD; segment flicker is ignored.
        if (AN != prev_reg[14:7]) begin
          if (an_onehot) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = SW'(1);
            prev_next       = sample;
          end else begin
            state_next      = ST_WAIT;
            settle_cnt_next = '0;
          end
        end
      end
      default: begin
        state_next      = ST_WAIT;
        settle_cnt_next = '0;
      end
    endcase
    // With a one-sample settle time the first valid sample is already stable.
    if (SETTLE_ONE && state_next == ST_SETTLE) begin
      capture         = 1'b1;
      state_next      = ST_HOLD;
      settle_cnt_next = '0;
    end
  end

  assign mask_done = (mask_reg == 8'hFF);

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (capture) begin
      stall_cnt_next = '0;
    end else if (stall_cnt_reg != STALL_MAX) begin
      stall_cnt_next = stall_cnt_reg + TW'(1);
    end
    mask_next = mask_done ? 8'h00 : mask_reg;
    if (capture) begin
      mask_next = mask_next | (8'h01 << pos);
    end else if (stall_cnt_next == STALL_MAX) begin
      mask_next = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_WAIT;
      settle_cnt_reg <= '0;
      prev_reg       <= '0;
      mask_reg       <= 8'h00;
      stall_cnt_reg  <= '0;
      stall_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      prev_reg       <= prev_next;
      mask_reg       <= mask_next;
      stall_cnt_reg  <= stall_cnt_next;
      stall_reg      <= (stall_cnt_next == STALL_MAX);
    end
  end

  // One code register per display position forms the working buffer.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pos
      logic [4:0] code_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          code_reg <= BLANK;
        end else if (capture && pos == 3'(gi)) begin
          code_reg <= cap_code;
        end
      end
      assign work_flat[5*gi +: 5] = code_reg;
    end
  endgenerate

  // first_reg forces frame_changed on the first frame even if it is all blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg   <= {8{BLANK}};
      valid_reg   <= 1'b0;
      changed_reg <= 1'b0;
      first_reg   <= 1'b1;
    end else begin
      valid_reg   <= mask_done;
      changed_reg <= mask_done && (first_reg || (work_flat != frame_reg));
      if (mask_done) begin
        frame_reg <= work_flat;
        first_reg <= 1'b0;
      end
    end
  end

  assign frame         = frame_reg;
  assign frame_valid   = valid_reg;
  assign frame_changed = changed_reg;
  assign scan_stall    = stall_reg;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: decode/AN tables, directed scan scenarios and random
// scanning, all checked every cycle against a run-length reference model.
module tb_seg_frame_decoder;

  localparam int SETTLE = 4;
  localparam int STALL  = 60;
  localparam logic [39:0] BLANK_FRAME = {8{5'd16}};

  logic        clk;
  logic        rst;
  logic [7:0]  AN;
  logic [6:0]  led;
  logic [39:0] frame;
  logic        frame_valid;
  logic        frame_changed;
  logic        bad_an;
  logic        scan_stall;

  seg_frame_decoder #(.SETTLE_CYCLES(SETTLE), .STALL_CYCLES(STALL)) dut (
    .clk(clk), .rst(rst), .AN(AN), .led(led), .frame(frame),
    .frame_valid(frame_valid), .frame_changed(frame_changed),
    .bad_an(bad_an), .scan_stall(scan_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [6:0] led; logic [4:0] code; } dec_t;
  typedef struct { logic [7:0] an; logic bad; } an_vec_t;
  dec_t    dec_tab [19];
  an_vec_t an_tab  [8];

  int n_checks = 0;
  int n_fail   = 0;
  int fv_count = 0;
  int fc_count = 0;
  logic [6:0] scan_led [8];

  // Reference model state
  logic [4:0]  m_work [8];
  logic [7:0]  m_seen;
  logic [39:0] m_frame;
  bit          m_first, m_pending, m_valid, m_changed, m_has_last, m_cap_seg;
  logic [7:0]  m_last_an;
  logic [6:0]  m_last_led;
  int          m_run, m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 19; i++) if (dec_tab[i].led == p) return dec_tab[i].code;
    return 5'd31;
  endfunction

  function automatic bit one_low(input logic [7:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic int low_pos(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (!a[i]) return i;
    return 0;
  endfunction

  function automatic logic [39:0] pack_work();
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[5*i +: 5] = m_work[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_work[i] = 5'd16;
    m_seen = 8'h00; m_frame = BLANK_FRAME; m_first = 1; m_pending = 0;
    m_valid = 0; m_changed = 0; m_has_last = 0; m_cap_seg = 0;
    m_last_an = 8'hFF; m_last_led = 7'h7F; m_run = 0; m_stall = 0;
  endtask

  // A digit is taken when its {AN,led} sample has been identical SETTLE times in
  // a row, once per continuous stretch of the same AN value.
  task automatic model_edge(input logic [7:0] a, input logic [6:0] l);
    bit cap;
    logic [39:0] snap;
    int p;
    m_valid = 0; m_changed = 0;
    if (m_pending) begin
      snap = pack_work();
      m_changed = m_first || (snap != m_frame);
      m_frame = snap; m_valid = 1; m_first = 0; m_seen = 8'h00; m_pending = 0;
    end
    if (!m_has_last || a != m_last_an) m_cap_seg = 0;
    if (m_has_last && a == m_last_an && l == m_last_led) m_run++;
    else m_run = 1;
    m_has_last = 1; m_last_an = a; m_last_led = l;
    cap = one_low(a) && (m_run >= SETTLE) && !m_cap_seg;
    if (cap) begin
      m_cap_seg = 1;
      p = low_pos(a);
      m_work[p] = ref_decode(l);
      m_seen[p] = 1'b1;
      m_stall = 0;
    end else if (m_stall < STALL) begin
      m_stall++;
    end
    if (!cap && m_stall == STALL) m_seen = 8'h00;
    if (m_seen == 8'hFF) m_pending = 1;
  endtask

  task automatic tick(input logic [7:0] a, input logic [6:0] l);
    AN = a; led = l;
    #1;
    check("bad_an", bad_an, !one_low(a));
    @(posedge clk);
    model_edge(a, l);
    #1;
    check("frame_valid", frame_valid, m_valid);
    check("frame_changed", frame_changed, m_changed);
    check("scan_stall", scan_stall, m_stall == STALL);
    check("frame", frame, m_frame);
    if (frame_valid) fv_count++;
    if (frame_changed) fc_count++;
  endtask

  task automatic scan(input logic [7:0] which, input int dwell);
    logic [7:0] a;
    for (int p = 0; p < 8; p++) begin
      if (which[p]) begin
        a = 8'h01 << p;
        a = ~a;
        repeat (dwell) tick(a, scan_led[p]);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(8'hFF, 7'h7F);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame"}, frame, BLANK_FRAME);
    check({tag, "_valid"}, frame_valid, 1'b0);
    check({tag, "_changed"}, frame_changed, 1'b0);
    check({tag, "_stall"}, scan_stall, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; AN = 8'hFF; led = 7'h7F;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");
  endtask

  task automatic load_digits(input int base);
    for (int p = 0; p < 8; p++) scan_led[p] = dec_tab[(base + p) % 19].led;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, c0, idx;
    logic [31:0] rv;
    logic [7:0] ra;
    logic [6:0] rl;
    int dw;

    dec_tab[0]  = '{7'b1000000, 5'd0};   dec_tab[1]  = '{7'b1111001, 5'd1};
    dec_tab[2]  = '{7'b0100100, 5'd2};   dec_tab[3]  = '{7'b0110000, 5'd3};
    dec_tab[4]  = '{7'b0011001, 5'd4};   dec_tab[5]  = '{7'b0010010, 5'd5};
    dec_tab[6]  = '{7'b0000010, 5'd6};   dec_tab[7]  = '{7'b1111000, 5'd7};
    dec_tab[8]  = '{7'b0000000, 5'd8};   dec_tab[9]  = '{7'b0010000, 5'd9};
    dec_tab[10] = '{7'b0001000, 5'd10};  dec_tab[11] = '{7'b0000011, 5'd11};
    dec_tab[12] = '{7'b1000110, 5'd12};  dec_tab[13] = '{7'b0100001, 5'd13};
    dec_tab[14] = '{7'b0000110, 5'd14};  dec_tab[15] = '{7'b0001110, 5'd15};
    dec_tab[16] = '{7'b1111111, 5'd16};  dec_tab[17] = '{7'b0111111, 5'd17};
    dec_tab[18] = '{7'b1010101, 5'd31};

    an_tab[0] = '{8'b11110011, 1'b1};  an_tab[1] = '{8'hFF, 1'b1};
    an_tab[2] = '{8'h00, 1'b1};        an_tab[3] = '{8'hFE, 1'b0};
    an_tab[4] = '{8'h7F, 1'b0};        an_tab[5] = '{8'b01111110, 1'b1};
    an_tab[6] = '{8'hEF, 1'b0};        an_tab[7] = '{8'hFB, 1'b0};

    do_reset();

    // "12345678" scan, then identical repeat, then p3 changed to E
    load_digits(1);
    f0 = fv_count; c0 = fc_count;
    scan(8'hFF, 6); idle(2);
    check("scan1_valid_pulses", fv_count - f0, 1);
    check("scan1_changed_pulses", fc_count - c0, 1);
    for (int p = 0; p < 8; p++) check("scan1_code", frame[5*p +: 5], p + 1);
    f0 = fv_count; c0 = fc_count;
    scan(8'hFF, 6); idle(2);
    check("repeat_valid_pulses", fv_count - f0, 1);
    check("repeat_changed_pulses", fc_count - c0, 0);
    scan_led[3] = dec_tab[14].led;
    f0 = fv_count; c0 = fc_count;
    scan(8'hFF, 6); idle(2);
    check("p3E_valid_pulses", fv_count - f0, 1);
    check("p3E_changed_pulses", fc_count - c0, 1);
    check("p3E_code", frame[19:15], 14);

    // Decode table swept through all positions
    for (int g = 0; g < 3; g++) begin
      load_digits(8 * g);
      scan(8'hFF, 6); idle(2);
      for (int p = 0; p < 8; p++) begin
        idx = (8 * g + p) % 19;
        check("decode_tab", frame[5*p +: 5], dec_tab[idx].code);
      end
    end

    // Short dwell and flickering segments on p2 never capture
    do_reset();
    load_digits(1);
    f0 = fv_count;
    scan(8'b00000011, 6); scan(8'b00000100, 3); scan(8'b11111000, 6); idle(2);
    check("short_dwell_no_frame", fv_count - f0, 0);
    for (int i = 0; i < 12; i++) tick(8'hFB, (i % 2 == 1) ? dec_tab[9].led : dec_tab[3].led);
    idle(1);
    check("toggle_no_frame", fv_count - f0, 0);
    scan_led[2] = dec_tab[9].led;
    scan(8'b00000100, 6); idle(2);
    check("p2_fill_frame", fv_count - f0, 1);
    check("p2_fill_code", frame[14:10], 9);
    check("p2_fill_p0", frame[4:0], 1);

    // bad_an table and invalid selections never captured
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(an_tab[i].an, dec_tab[8].led);
      check("an_tab", bad_an, an_tab[i].bad);
    end
    do_reset();
    load_digits(1);
    f0 = fv_count;
    scan(8'b11111011, 6);
    repeat (8) tick(8'b11110011, dec_tab[5].led);
    repeat (8) tick(8'b11111010, dec_tab[5].led);
    repeat (8) tick(8'hFF, dec_tab[5].led);
    check("bad_an_no_frame", fv_count - f0, 0);
    scan_led[2] = dec_tab[18].led;
    scan(8'b00000100, 6); idle(2);
    check("unknown_frame", fv_count - f0, 1);
    check("unknown_code", frame[14:10], 31);

    // Stall discards the partial frame, next capture clears scan_stall
    do_reset();
    load_digits(1);
    scan(8'h1F, 6); idle(STALL + 2);
    check("stall_set", scan_stall, 1'b1);
    f0 = fv_count;
    scan(8'h20, 6);
    check("stall_cleared", scan_stall, 1'b0);
    scan(8'hC0, 6); idle(2);
    check("stall_mask_cleared", fv_count - f0, 0);
    scan(8'h1F, 6); idle(2);
    check("stall_full_scan", fv_count - f0, 1);

    // Asynchronous reset mid-frame
    do_reset();
    load_digits(1);
    scan(8'hFF, 6); idle(2);
    load_digits(10);
    scan(8'h3F, 6);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_release");
    f0 = fv_count; c0 = fc_count;
    scan(8'hC0, 6); idle(2);
    check("rst_partial_discarded", fv_count - f0, 0);
    scan(8'hFF, 6); idle(2);
    check("rst_new_frame", fv_count - f0, 1);
    check("rst_first_changed", fc_count - c0, 1);

    // Random scanning against the model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      rv = $urandom_range(0, 9);
      if (rv < 8) begin
        ra = 8'h01 << rv[2:0];
        ra = ~ra;
        dw = $urandom_range(1, 8);
      end else if (rv == 8) begin
        ra = 8'hFF;
        dw = $urandom_range(1, 70);
      end else begin
        rv = $urandom;
        ra = rv[7:0];
        dw = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 3) == 0) begin
        rv = $urandom;
        rl = rv[6:0];
      end else begin
        rl = dec_tab[$urandom_range(0, 18)].led;
      end
      repeat (dw) tick(ra, rl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 4: number of consecutive identical samples of {AN, led} required before a digit is captured.
REQ-002 The module SHALL have parameter STALL_CYCLES, default 100000: number of cycles without a new capture before a stall is declared.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 AN  input  8  digit enable, active-low; exactly one bit low selects digit position 0..7 (bit index = position).
REQ-006 led  input  7  segment pattern, active-low; led[0]=a, led[1]=b, … led[6]=g.
REQ-007 frame  output  40  decoded frame; bits [5p+4:5p] hold the code of position p.
REQ-008 frame_valid  output  1  one-cycle pulse when a complete 8-position frame is captured.
REQ-009 frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous completed frame.
REQ-010 bad_an  output  1  level, high for each cycle in which AN is not one-hot-low.
REQ-011 scan_stall  output  1  level, high while no capture has occurred for STALL_CYCLES cycles.

Function
REQ-012 Decode table (led value -> code): 0 -> 0; 7'b1111001 -> 1; 7'b0100100 -> 2; 7'b0110000 -> 3; 7'b0011001 -> 4; 7'b0010010 -> 5; 7'b0000010 -> 6; 7'b1111000 -> 7; 7'b0000000 -> 8; 7'b0010000 -> 9; A 7'b0001000 -> 10; b 7'b0000011 -> 11; C 7'b1000110 -> 12; d 7'b0100001 -> 13; E 7'b0000110 -> 14; F 7'b0001110 -> 15; blank 7'b1111111 -> 16; dash 7'b0111111 -> 17; any other pattern -> 31.
REQ-013 States: WAIT (no valid selection), SETTLE (counting stable samples), HOLD (digit captured, waiting for AN to change).
REQ-014 WAIT -> SETTLE when AN is one-hot-low; the settle counter loads 1.
REQ-015 In SETTLE, if {AN, led} equals the previous cycle's value, the counter increments; otherwise the counter restarts at 1, or the FSM returns to WAIT if AN is invalid.
REQ-016 When the counter reaches SETTLE_CYCLES, the decoded code SHALL be written to its position in a working buffer, that position's seen-mask bit SHALL be set, and the FSM SHALL go to HOLD.
REQ-017 Capture latency: a write occurs on the SETTLE_CYCLES-th consecutive identical sample; frame outputs update one cycle after the capture that completes the mask.
REQ-018 In HOLD, changes to led with AN unchanged SHALL be ignored; when AN changes, the FSM SHALL go to SETTLE (valid AN) or WAIT (invalid AN).
REQ-019 A re-capture of an already-seen position SHALL overwrite its code without completing the frame early.
REQ-020 When the seen mask becomes 8'hFF, the module SHALL: copy the working buffer to frame; pulse frame_valid; pulse frame_changed if the new frame differs from the old frame value; and clear the mask in the same cycle.
REQ-021 The first frame after reset SHALL assert frame_changed.
REQ-022 bad_an SHALL be combinational from AN (high when AN is 8'hFF or has two or more low bits); invalid samples SHALL never be captured.
REQ-023 The stall counter SHALL clear on every capture and saturate at STALL_CYCLES.
REQ-024 At saturation, the stall counter SHALL assert scan_stall and clear the seen mask (partial frame discarded); the next capture SHALL deassert scan_stall.
REQ-025 Capture and mask completion in the same cycle as stall saturation: the capture wins, and the stall counter clears.

Reset
REQ-026 On rst high, the module SHALL immediately and asynchronously set: FSM to WAIT; settle counter, stall counter, and seen mask to 0; working buffer and frame to all-16 (blank); frame_valid, frame_changed, and scan_stall to 0.
REQ-027 A reset mid-frame SHALL discard all partial captures; no frame_valid is produced until 8 positions are captured after release.

Verification
REQ-028 Scan positions 0..7 showing "12345678", dwell 6 cycles each -> one frame_valid and one frame_changed; frame codes 1,2,3,4,5,6,7,8 at p0..p7.
REQ-029 Repeat the identical scan -> frame_valid pulses, frame_changed stays 0; a second repeat with p3=E -> frame_changed=1 and p3 code 14.
REQ-030 Dwell of 3 cycles (< SETTLE_CYCLES) on p2, or led toggling every cycle -> no capture at p2 and no frame_valid.
REQ-031 AN=8'b11110011 or 8'hFF -> bad_an=1, no capture; unknown pattern 7'b1010101 -> code 31.
REQ-032 Capture p0..p4, then hold AN=8'hFF for STALL_CYCLES -> scan_stall=1 and mask cleared; a full scan afterwards -> scan_stall=0 and one frame_valid.
REQ-033 Assert rst after p0..p5 are captured, then release -> all outputs at reset values; frame_valid only after 8 new captures.
